// File: rtl/mac_stop_mem_pkg.sv
// rtl/mac_stop_mem_pkg.sv - shared types and width helpers for the MAC matrix store
package mac_stop_mem_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    typedef enum logic [1:0] {SEL_A = 2'd0, SEL_B = 2'd1, SEL_C = 2'd2} ld_sel_t;

    localparam logic [1:0] SEL_RSVD = 2'd3;

    function automatic int result_width(input int dw, input int k);
        return 2 * dw + $clog2(k);
    endfunction

    // Width of a row/column counter able to walk the largest matrix dimension.
    function automatic int dim_width(input int m, input int k, input int n);
        int mx;
        mx = m;
        if (k > mx) mx = k;
        if (n > mx) mx = n;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_mem_stream_ctrl.sv
// rtl/mac_stop_mem_stream_ctrl.sv - burst load / drain FSM with row-major row/col counter
module mac_stop_mem_stream_ctrl
    import mac_stop_mem_pkg::*;
#(
    parameter int M    = 4,
    parameter int K    = 4,
    parameter int N    = 4,
    parameter int DIMW = dim_width(M, K, N)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ld_start,
    input  logic [1:0]      ld_sel,
    input  logic            ld_valid,
    input  logic            dr_start,
    input  logic            dr_ready,
    output logic            busy,
    output logic            ld_ready,
    output logic            ld_done,
    output logic            ld_we,
    output logic            dr_valid,
    output logic            dr_last,
    output ld_sel_t         ld_tgt,
    output logic [DIMW-1:0] row,
    output logic [DIMW-1:0] col
);

    localparam logic [DIMW-1:0] ONE = DIMW'(1);

    state_t          state;
    logic [DIMW-1:0] rows_m1;
    logic [DIMW-1:0] cols_m1;
    logic            at_last;

    always_comb begin
        rows_m1 = DIMW'(M - 1);
        cols_m1 = DIMW'(N - 1);
        case (ld_tgt)
            SEL_A:   begin rows_m1 = DIMW'(M - 1); cols_m1 = DIMW'(K - 1); end
            SEL_B:   begin rows_m1 = DIMW'(K - 1); cols_m1 = DIMW'(N - 1); end
            default: begin rows_m1 = DIMW'(M - 1); cols_m1 = DIMW'(N - 1); end
        endcase
    end

    assign at_last = (row == rows_m1) && (col == cols_m1);
    assign ld_we   = (state == LOAD) && ld_valid;
    assign dr_last = dr_valid && at_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ld_tgt   <= SEL_A;
            row      <= '0;
            col      <= '0;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            dr_valid <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                    // Load has priority over drain when both starts arrive together.
                    if (ld_start && (ld_sel != SEL_RSVD)) begin
                        state    <= LOAD;
                        ld_tgt   <= ld_sel_t'(ld_sel);
                        busy     <= 1'b1;
                        ld_ready <= 1'b1;
                    end else if (dr_start) begin
                        state    <= DRAIN;
                        ld_tgt   <= SEL_C;
                        busy     <= 1'b1;
                        dr_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        if (at_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end else if (col == cols_m1) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (dr_ready) begin
                        if (at_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            dr_valid <= 1'b0;
                        end else if (col == cols_m1) begin
                            col <= '0;
                            row <= row + ONE;
                        end else begin
                            col <= col + ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mac_stop_mem_stream.sv
// rtl/mac_stop_mem_stream.sv - A/B/C matrix store with random port, burst load and C drain; MAC_STOP_MEM_STREAM_ACC_EN enables C accumulate
module mac_stop_mem_stream
    import mac_stop_mem_pkg::*;
#(
    parameter int M                        = 4,
    parameter int K                        = 4,
    parameter int N                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
    input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    input  logic [$clog2(M)-1:0]                row_addr_a,
    input  logic [$clog2(M)-1:0]                row_addr_c,
    input  logic [$clog2(K)-1:0]                col_addr_a,
    input  logic [$clog2(K)-1:0]                row_addr_b,
    input  logic [$clog2(N)-1:0]                col_addr_b,
    input  logic [$clog2(N)-1:0]                col_addr_c,
    input  logic                                matrix_a_we,
    input  logic                                matrix_b_we,
    input  logic                                matrix_c_we,
    input  logic                                matrix_a_re,
    input  logic                                matrix_b_re,
    input  logic                                matrix_c_re,
    input  logic                                matrix_c_acc,
    output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c,
    output logic                                rd_valid_a,
    output logic                                rd_valid_b,
    output logic                                rd_valid_c,
    input  logic                                ld_start,
    input  logic [1:0]                          ld_sel,
    input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] ld_data,
    input  logic                                ld_valid,
    output logic                                ld_ready,
    output logic                                ld_done,
    input  logic                                dr_start,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] dr_data,
    output logic                                dr_valid,
    input  logic                                dr_ready,
    output logic                                dr_last,
    output logic                                busy
);

    localparam int DW   = DATA_WIDTH_INIT_MATRIX;
    localparam int RW   = DATA_WIDTH_RESULT_MATRIX;
    localparam int AM   = $clog2(M);
    localparam int AK   = $clog2(K);
    localparam int AN   = $clog2(N);
    localparam int DIMW = dim_width(M, K, N);

    logic [M-1:0][K-1:0][DW-1:0] mem_a;
    logic [K-1:0][N-1:0][DW-1:0] mem_b;
    logic [M-1:0][N-1:0][RW-1:0] mem_c;

    ld_sel_t         ld_tgt;
    logic            ld_we;
    logic [DIMW-1:0] row;
    logic [DIMW-1:0] col;
    logic            re_a, re_b, re_c;
    logic [RW-1:0]   c_wdata;

    mac_stop_mem_stream_ctrl #(.M(M), .K(K), .N(N), .DIMW(DIMW)) u_ctrl (
        .clk      (clk),
        .resetn   (resetn),
        .ld_start (ld_start),
        .ld_sel   (ld_sel),
        .ld_valid (ld_valid),
        .dr_start (dr_start),
        .dr_ready (dr_ready),
        .busy     (busy),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_we    (ld_we),
        .dr_valid (dr_valid),
        .dr_last  (dr_last),
        .ld_tgt   (ld_tgt),
        .row      (row),
        .col      (col)
    );

    assign re_a = matrix_a_re && !busy;
    assign re_b = matrix_b_re && !busy;
    assign re_c = matrix_c_re && !busy;

`ifdef MAC_STOP_MEM_STREAM_ACC_EN
    assign c_wdata = matrix_c_acc ? (mem_c[row_addr_c][col_addr_c] + data_in_c) : data_in_c;
`else
    logic unused_acc;
    assign unused_acc = matrix_c_acc;
    assign c_wdata    = data_in_c;
`endif

    // C cannot change while draining, so the combinational view is stable under backpressure.
    assign dr_data = dr_valid ? mem_c[row[AM-1:0]][col[AN-1:0]] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_a      <= '0;
            mem_b      <= '0;
            mem_c      <= '0;
            data_out_a <= '0;
            data_out_b <= '0;
            data_out_c <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            rd_valid_c <= 1'b0;
        end else begin
            rd_valid_a <= re_a;
            rd_valid_b <= re_b;
            rd_valid_c <= re_c;
            data_out_a <= re_a ? mem_a[row_addr_a][col_addr_a] : '0;
            data_out_b <= re_b ? mem_b[row_addr_b][col_addr_b] : '0;
            data_out_c <= re_c ? mem_c[row_addr_c][col_addr_c] : '0;

            if (ld_we) begin
                case (ld_tgt)
                    SEL_A:   mem_a[row[AM-1:0]][col[AK-1:0]] <= ld_data[DW-1:0];
                    SEL_B:   mem_b[row[AK-1:0]][col[AN-1:0]] <= ld_data[DW-1:0];
                    default: mem_c[row[AM-1:0]][col[AN-1:0]] <= ld_data;
                endcase
            end

            if (matrix_a_we && !busy) mem_a[row_addr_a][col_addr_a] <= data_in_a;
            if (matrix_b_we && !busy) mem_b[row_addr_b][col_addr_b] <= data_in_b;
            if (matrix_c_we && !busy) mem_c[row_addr_c][col_addr_c] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_mac_stop_mem_stream.sv
// tb/tb_mac_stop_mem_stream.sv - directed self-checking bench for mac_stop_mem_stream
module tb_mac_stop_mem_stream;

    localparam int M  = 4;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 18;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] data_in_a, data_in_b;
    logic [RW-1:0] data_in_c;
    logic [1:0]    row_addr_a, row_addr_c, col_addr_a, row_addr_b, col_addr_b, col_addr_c;
    logic          matrix_a_we, matrix_b_we, matrix_c_we;
    logic          matrix_a_re, matrix_b_re, matrix_c_re, matrix_c_acc;
    logic [DW-1:0] data_out_a, data_out_b;
    logic [RW-1:0] data_out_c;
    logic          rd_valid_a, rd_valid_b, rd_valid_c;
    logic          ld_start;
    logic [1:0]    ld_sel;
    logic [RW-1:0] ld_data;
    logic          ld_valid, ld_ready, ld_done;
    logic          dr_start;
    logic [RW-1:0] dr_data;
    logic          dr_valid, dr_ready, dr_last, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_stop_mem_stream #(
        .M(M), .K(K), .N(N),
        .DATA_WIDTH_INIT_MATRIX(DW),
        .DATA_WIDTH_RESULT_MATRIX(RW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .data_in_a(data_in_a), .data_in_b(data_in_b), .data_in_c(data_in_c),
        .row_addr_a(row_addr_a), .row_addr_c(row_addr_c),
        .col_addr_a(col_addr_a), .row_addr_b(row_addr_b),
        .col_addr_b(col_addr_b), .col_addr_c(col_addr_c),
        .matrix_a_we(matrix_a_we), .matrix_b_we(matrix_b_we), .matrix_c_we(matrix_c_we),
        .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .matrix_c_re(matrix_c_re),
        .matrix_c_acc(matrix_c_acc),
        .data_out_a(data_out_a), .data_out_b(data_out_b), .data_out_c(data_out_c),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b), .rd_valid_c(rd_valid_c),
        .ld_start(ld_start), .ld_sel(ld_sel), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done),
        .dr_start(dr_start), .dr_data(dr_data), .dr_valid(dr_valid),
        .dr_ready(dr_ready), .dr_last(dr_last), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v, cyc, done_cnt, got, k;
        logic acc;

        resetn = 1'b0;
        data_in_a = '0; data_in_b = '0; data_in_c = '0;
        row_addr_a = '0; row_addr_c = '0; col_addr_a = '0;
        row_addr_b = '0; col_addr_b = '0; col_addr_c = '0;
        matrix_a_we = 0; matrix_b_we = 0; matrix_c_we = 0;
        matrix_a_re = 0; matrix_b_re = 0; matrix_c_re = 0; matrix_c_acc = 0;
        ld_start = 0; ld_sel = 0; ld_data = '0; ld_valid = 0;
        dr_start = 0; dr_ready = 1;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_dr_valid", dr_valid, 0);
        chk("rst_dr_last", dr_last, 0);
        chk("rst_rd_valid_a", rd_valid_a, 0);
        chk("rst_data_out_c", data_out_c, 0);
        resetn = 1'b1;
        step();

        // Reserved load target is ignored
        ld_start = 1; ld_sel = 2'd3;
        step();
        chk("rsvd_sel_busy", busy, 0);
        ld_start = 0;

        // Random write then read of A[1][2]
        matrix_a_we = 1; row_addr_a = 1; col_addr_a = 2; data_in_a = 8'h5A;
        step();
        matrix_a_we = 0; matrix_a_re = 1;
        step();
        chk("rd_a_data", data_out_a, 8'h5A);
        chk("rd_a_valid", rd_valid_a, 1);
        matrix_a_we = 1; data_in_a = 8'h33;
        step();
        chk("rd_a_prewrite", data_out_a, 8'h5A);
        matrix_a_we = 0;
        step();
        chk("rd_a_new", data_out_a, 8'h33);
        matrix_a_re = 0;
        step();
        chk("rd_a_idle_data", data_out_a, 0);
        chk("rd_a_idle_valid", rd_valid_a, 0);

        // C write then accumulate with wrap
        matrix_c_we = 1; row_addr_c = 0; col_addr_c = 0; data_in_c = 18'h3FFFF;
        step();
        matrix_c_acc = 1; data_in_c = 18'h2;
        step();
        matrix_c_we = 0; matrix_c_acc = 0; matrix_c_re = 1;
        step();
`ifdef MAC_STOP_MEM_STREAM_ACC_EN
        chk("acc_wrap", data_out_c, 18'h00001);
`else
        chk("acc_off", data_out_c, 18'h00002);
`endif
        matrix_c_re = 0;

        // Burst-load B with 1..16, ld_valid every other cycle
        ld_start = 1; ld_sel = 2'd1;
        step();
        ld_start = 0;
        chk("ldb_busy", busy, 1);
        chk("ldb_ready", ld_ready, 1);
        v = 1; cyc = 0; done_cnt = 0;
        while (v <= 16 && cyc < 100) begin
            ld_valid = (cyc % 2 == 0);
            ld_data  = RW'(v);
            acc = ld_valid && ld_ready;
            step();
            if (acc) v++;
            if (ld_done) done_cnt++;
            cyc++;
        end
        chk("ldb_count", v, 17);
        chk("ldb_done_at_end", ld_done, 1);
        ld_valid = 0;
        step();
        if (ld_done) done_cnt++;
        step();
        if (ld_done) done_cnt++;
        chk("ldb_done_once", done_cnt, 1);
        chk("ldb_idle", busy, 0);
        matrix_b_re = 1; row_addr_b = 3; col_addr_b = 3;
        step();
        chk("b33", data_out_b, 16);
        chk("b33_valid", rd_valid_b, 1);
        row_addr_b = 1; col_addr_b = 0;
        step();
        chk("b10", data_out_b, 5);
        matrix_b_re = 0;

        // Load C with 0..15 at full rate
        ld_start = 1; ld_sel = 2'd2;
        step();
        ld_start = 0;
        ld_valid = 1;
        for (int i = 0; i < 16; i++) begin
            ld_data = RW'(i);
            step();
        end
        ld_valid = 0;
        chk("ldc_done", ld_done, 1);

        // Drain C with a three-cycle stall
        dr_start = 1;
        step();
        dr_start = 0;
        got = 0; k = 0;
        while (got < 16 && k < 60) begin
            dr_ready = !(k >= 3 && k <= 5);
            chk("dr_valid", dr_valid, 1);
            chk("dr_data", dr_data, got);
            chk("dr_last", dr_last, (got == 15));
            acc = dr_valid && dr_ready;
            step();
            if (acc) got++;
            k++;
        end
        chk("dr_count", got, 16);
        chk("dr_end_valid", dr_valid, 0);
        chk("dr_end_busy", busy, 0);

        // Reset in the middle of a drain
        dr_start = 1;
        step();
        dr_start = 0;
        step();
        step();
        chk("dr_mid_data", dr_data, 2);
        resetn = 0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_dr_valid", dr_valid, 0);
        step();
        resetn = 1;
        matrix_c_re = 1; row_addr_c = 2; col_addr_c = 3;
        step();
        chk("rstmid_c23", data_out_c, 0);
        chk("rstmid_c23_valid", rd_valid_c, 1);
        matrix_c_re = 0;

        // Simultaneous starts: load wins, drain start ignored during load
        ld_start = 1; dr_start = 1; ld_sel = 2'd0;
        step();
        ld_start = 0;
        chk("both_busy", busy, 1);
        chk("both_ld_ready", ld_ready, 1);
        chk("both_dr_valid", dr_valid, 0);
        matrix_a_re = 1; row_addr_a = 0; col_addr_a = 0;
        step();
        chk("load_dr_valid", dr_valid, 0);
        chk("load_rd_valid_a", rd_valid_a, 0);
        dr_start = 0; matrix_a_re = 0;
        ld_valid = 1;
        for (int i = 0; i < 16; i++) begin
            ld_data = RW'(100 + i);
            step();
            if (i < 15) chk("lda_no_dr_valid", dr_valid, 0);
        end
        ld_valid = 0;
        chk("lda_done", ld_done, 1);
        matrix_a_re = 1; row_addr_a = 1; col_addr_a = 2;
        step();
        chk("a12_loaded", data_out_a, 8'h6A);
        matrix_a_re = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
